// File: rtl/branch_target_buffer_if.sv
// IF/EX-side signal bundle between the RV32I pipeline and the branch target buffer.
interface branch_target_buffer_if;
  logic [31:0] PCF;
  logic        PredictTakenF;
  logic [31:0] PredictedTargetF;
  logic [2:0]  BranchTypeE;
  logic        BranchE;
  logic [31:0] PCE;
  logic [31:0] BranchTargetE;
  logic        PredictedTakenE;
  logic [31:0] PredictedTargetE;
  logic        MispredictE;
  logic [31:0] RecoveryPCE;
  logic [31:0] BranchCountS;
  logic [31:0] MispredictCountS;

  modport master (
    output PCF, BranchTypeE, BranchE, PCE, BranchTargetE, PredictedTakenE, PredictedTargetE,
    input  PredictTakenF, PredictedTargetF, MispredictE, RecoveryPCE, BranchCountS, MispredictCountS
  );

  modport slave (
    input  PCF, BranchTypeE, BranchE, PCE, BranchTargetE, PredictedTakenE, PredictedTargetE,
    output PredictTakenF, PredictedTargetF, MispredictE, RecoveryPCE, BranchCountS, MispredictCountS
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating direction counters; combinational IF lookup, EX training.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module branch_target_buffer #(
  parameter int INDEX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_target_buffer_if.slave btb
);
  localparam int TAG_W   = 30 - INDEX_W;
  localparam int ENTRIES = 1 << INDEX_W;
  localparam logic [2:0] NOBRANCH = 3'd0;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [INDEX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]   tag_f, tag_e;
  logic               hit_f, hit_e, upd_e, mispredict_e;
  logic [31:0]        pc_plus4_e;
  logic               unused_pc_lsbs;

  assign idx_f = btb.PCF[INDEX_W+1:2];
  assign tag_f = btb.PCF[31:INDEX_W+2];
  assign idx_e = btb.PCE[INDEX_W+1:2];
  assign tag_e = btb.PCE[31:INDEX_W+2];
  assign unused_pc_lsbs = ^btb.PCF[1:0];

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  assign btb.PredictTakenF    = hit_f && ctr_q[idx_f][1] && !rst;
  assign btb.PredictedTargetF = btb.PredictTakenF ? target_q[idx_f] : 32'd0;

  // Bubbles flushed out of EX carry NOBRANCH and must never train or flag.
  assign upd_e      = (btb.BranchTypeE != NOBRANCH) && !rst;
  assign pc_plus4_e = btb.PCE + 32'd4;

  assign mispredict_e = upd_e &&
                        ((btb.BranchE != btb.PredictedTakenE) ||
                         (btb.BranchE && btb.PredictedTakenE &&
                          (btb.PredictedTargetE != btb.BranchTargetE)));
  assign btb.MispredictE = mispredict_e;
  assign btb.RecoveryPCE = (btb.BranchE && !rst) ? btb.BranchTargetE : pc_plus4_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_e) begin
      if (hit_e) begin
        if (btb.BranchE) begin
          ctr_q[idx_e]    <= sat_inc(ctr_q[idx_e]);
          target_q[idx_e] <= btb.BranchTargetE;
        end else begin
          ctr_q[idx_e] <= sat_dec(ctr_q[idx_e]);
        end
      end else if (btb.BranchE) begin
        // Taken miss allocates, evicting whatever aliased into this slot.
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= btb.BranchTargetE;
        ctr_q[idx_e]    <= 2'b10;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q     <= 32'd0;
      mispredict_cnt_q <= 32'd0;
    end else begin
      if (upd_e && (branch_cnt_q != 32'hFFFF_FFFF))
        branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict_e && (mispredict_cnt_q != 32'hFFFF_FFFF))
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign btb.BranchCountS     = branch_cnt_q;
  assign btb.MispredictCountS = mispredict_cnt_q;
`else
  assign btb.BranchCountS     = 32'd0;
  assign btb.MispredictCountS = 32'd0;
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: a reference table model predicts every output each cycle.
module tb_branch_target_buffer;
  localparam int INDEX_W = 4;
  localparam int ENTRIES = 1 << INDEX_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_target_buffer_if bus();

  branch_target_buffer #(.INDEX_W(INDEX_W)) dut (
    .clk (clk),
    .rst (rst),
    .btb (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference table
  logic        m_valid [ENTRIES];
  logic [25:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  logic [1:0]  m_ctr   [ENTRIES];
  logic [31:0] m_brcnt, m_miscnt;
  bit          m_init = 0;

  logic        c_rst, c_br, c_upd, c_mis;
  logic [31:0] c_pce, c_tgt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      0:       return {31'd0, bus.PredictTakenF};
      1:       return bus.PredictedTargetF;
      2:       return {31'd0, bus.MispredictE};
      3:       return bus.RecoveryPCE;
      4:       return bus.BranchCountS;
      default: return bus.MispredictCountS;
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [31:0] pcf, input logic [2:0] bt,
                       input logic br, input logic [31:0] pce, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptg);
    logic [3:0]  ix;
    logic        hit, eptf;
    rst                  = r;
    bus.PCF              = pcf;
    bus.BranchTypeE      = bt;
    bus.BranchE          = br;
    bus.PCE              = pce;
    bus.BranchTargetE    = tgt;
    bus.PredictedTakenE  = pt;
    bus.PredictedTargetE = ptg;
    ix   = pcf[5:2];
    hit  = m_init && m_valid[ix] && (m_tag[ix] == pcf[31:6]);
    eptf = !r && hit && m_ctr[ix][1];
    c_rst = r;
    c_br  = br;
    c_pce = pce;
    c_tgt = tgt;
    c_upd = (bt != 3'd0) && !r;
    c_mis = c_upd && ((br != pt) || (br && pt && (ptg != tgt)));
    push("predict_taken_f", 0, {31'd0, eptf});
    push("predicted_target_f", 1, eptf ? m_tgt[ix] : 32'd0);
    push("mispredict_e", 2, {31'd0, c_mis});
    push("recovery_pc_e", 3, (br && !r) ? tgt : pce + 32'd4);
    if (m_init) begin
`ifdef BTB_STATS_EN
      push("branch_count_s", 4, m_brcnt);
      push("mispredict_count_s", 5, m_miscnt);
`else
      push("branch_count_s", 4, 32'd0);
      push("mispredict_count_s", 5, 32'd0);
`endif
    end
  endtask

  task automatic settle();
    exp_t        e;
    logic [3:0]  ix;
    logic        hit;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.kind), e.val);
    end
    if (c_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_tag[i]   = '0;
        m_tgt[i]   = 32'd0;
        m_ctr[i]   = 2'b01;
      end
      m_brcnt  = 32'd0;
      m_miscnt = 32'd0;
      m_init   = 1;
    end else if (c_upd && m_init) begin
      ix  = c_pce[5:2];
      hit = m_valid[ix] && (m_tag[ix] == c_pce[31:6]);
      if (hit && c_br) begin
        if (m_ctr[ix] != 2'b11) m_ctr[ix] = m_ctr[ix] + 2'b01;
        m_tgt[ix] = c_tgt;
      end else if (hit) begin
        if (m_ctr[ix] != 2'b00) m_ctr[ix] = m_ctr[ix] - 2'b01;
      end else if (c_br) begin
        m_valid[ix] = 1'b1;
        m_tag[ix]   = c_pce[31:6];
        m_tgt[ix]   = c_tgt;
        m_ctr[ix]   = 2'b10;
      end
      if (m_brcnt != 32'hFFFF_FFFF) m_brcnt = m_brcnt + 32'd1;
      if (c_mis && m_miscnt != 32'hFFFF_FFFF) m_miscnt = m_miscnt + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] pcf);
    drive(1'b0, pcf, 3'd0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic train(input logic [31:0] pcf, input logic [31:0] pce, input logic br,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
    drive(1'b0, pcf, 3'd1, br, pce, tgt, pt, ptg);
  endtask

  logic [31:0] pcs [5];
  logic [31:0] tgts [3];

  initial begin
    pcs[0] = 32'h0000_0040; pcs[1] = 32'h0000_0080; pcs[2] = 32'h0000_00C4;
    pcs[3] = 32'h0000_0044; pcs[4] = 32'hFFFF_FFFC;
    tgts[0] = 32'h0000_0100; tgts[1] = 32'h0000_0200; tgts[2] = 32'h0000_0300;

    @(posedge clk);
    #1;
    // Reset for two cycles
    drive(1'b1, 32'h40, 3'd1, 1'b1, 32'h40, 32'h100, 1'b0, 32'h0);
    push("reset_mis", 2, 32'd0);
    push("reset_rec", 3, 32'h44);
    settle();
    drive(1'b1, 32'h40, 3'd0, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
    settle();
    idle(32'h40);
    push("post_reset_ptf", 0, 32'd0);
    push("post_reset_ptgt", 1, 32'd0);
    push("post_reset_brcnt", 4, 32'd0);
    settle();

    // Allocate
    train(32'h40, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    push("alloc_mis", 2, 32'd1);
    push("alloc_rec", 3, 32'h100);
    settle();
    idle(32'h40);
    push("alloc_hit_ptf", 0, 32'd1);
    push("alloc_hit_ptgt", 1, 32'h100);
    settle();

    // Saturation
    for (int i = 0; i < 3; i++) begin
      train(32'h40, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      push("train_taken_mis", 2, 32'd0);
      settle();
    end
    train(32'h40, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    push("sat_nt_mis", 2, 32'd1);
    push("sat_nt_rec", 3, 32'h44);
    settle();
    idle(32'h40);
    push("sat_still_taken", 0, 32'd1);
    settle();
    train(32'h40, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    settle();
    idle(32'h40);
    push("sat_now_nt", 0, 32'd0);
    settle();

    // Not-taken recovery with wraparound, no allocation
    train(32'h40, 32'hFFFF_FFFC, 1'b0, 32'h500, 1'b1, 32'h500);
    push("wrap_mis", 2, 32'd1);
    push("wrap_rec", 3, 32'h0);
    settle();
    idle(32'hFFFF_FFFC);
    push("wrap_no_alloc", 0, 32'd0);
    settle();

    // Alias eviction and read-during-write
    train(32'h40, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    settle();
    idle(32'h40);
    push("retrain_hit", 0, 32'd1);
    settle();
    train(32'h80, 32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    push("rdw_miss", 0, 32'd0);
    settle();
    idle(32'h80);
    push("rdw_next_hit", 0, 32'd1);
    push("rdw_next_tgt", 1, 32'h200);
    settle();
    idle(32'h40);
    push("alias_evicted", 0, 32'd0);
    settle();

    // Bubble with BranchE=1
    drive(1'b0, 32'h80, 3'd0, 1'b1, 32'h80, 32'h999, 1'b0, 32'h0);
    push("bubble_mis", 2, 32'd0);
    settle();
    idle(32'h80);
    push("bubble_tgt_kept", 1, 32'h200);
    settle();

    // Back-to-back decrements then an increment
    train(32'h80, 32'h80, 1'b0, 32'h200, 1'b1, 32'h200);
    settle();
    train(32'h80, 32'h80, 1'b0, 32'h200, 1'b0, 32'h0);
    settle();
    train(32'h80, 32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    push("b2b_ptf", 0, 32'd0);
    settle();
    idle(32'h80);
    push("b2b_after_inc", 0, 32'd0);
    settle();

    // Random traffic with occasional mid-training reset
    for (int n = 0; n < 300; n++) begin
      logic [2:0] bt;
      bt = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      drive(($urandom_range(0, 39) == 0), pcs[$urandom_range(0, 4)], bt,
            1'($urandom_range(0, 1)), pcs[$urandom_range(0, 4)], tgts[$urandom_range(0, 2)],
            1'($urandom_range(0, 1)), tgts[$urandom_range(0, 2)]);
      settle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters for the prediction-enabled RV32I pipeline. It sits downstream of the EX-stage branch decision logic. It also feeds the IF-stage next-PC mux.
- **IF side:** looks up the fetch PC combinationally and supplies a predicted direction and target.
- **EX side:** consumes the resolved `BranchE` and branch target, trains the table, and flags mispredictions with the recovery PC.

## Interface
Parameters:
- `INDEX_W`, default 4: index width. The table has 2^INDEX_W entries, indexed by PC[INDEX_W+1:2].
- `TAG_W`, fixed as 30-INDEX_W: tag is PC[31:INDEX_W+2].

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PCF`  in  32  fetch PC.
- `PredictTakenF`  out  1  predicted taken for PCF.
- `PredictedTargetF`  out  32  predicted target; 0 when PredictTakenF=0.
- `BranchTypeE`  in  3  branch type of the EX instruction; `NOBRANCH` (0) means no update.
- `BranchE`  in  1  resolved direction from branch decision logic.
- `PCE`  in  32  PC of the EX instruction.
- `BranchTargetE`  in  32  computed branch target.
- `PredictedTakenE`  in  1  PredictTakenF piped from IF to EX.
- `PredictedTargetE`  in  32  PredictedTargetF piped from IF to EX.
- `MispredictE`  out  1  misprediction; the pipeline flushes IF/ID and redirects.
- `RecoveryPCE`  out  32  correct next PC when MispredictE=1.
- `BranchCountS`  out  32  resolved-branch count (statistics build only).
- `MispredictCountS`  out  32  misprediction count (statistics build only).

## Operation
- **Entry contents:** valid, tag, target[31:0], ctr[1:0]. Counter encoding: 00 strongly-NT, 01 weakly-NT, 10 weakly-T, 11 strongly-T.
- **Lookup (combinational):**
  - hitF = valid[idxF] && tag[idxF]==PCF[31:INDEX_W+2].
  - PredictTakenF = hitF && ctr[idxF][1] && !rst.
  - PredictedTargetF = PredictTakenF ? target[idxF] : 0.
- **Update enable:** updE = (BranchTypeE != `NOBRANCH`) && !rst. Flushed bubbles carry NOBRANCH and never train the table.
- **Update on hit (valid && tag match at idxE):**
  - BranchE=1: ctr saturating +1 (11 stays 11); target <= BranchTargetE.
  - BranchE=0: ctr saturating -1 (00 stays 00); target unchanged.
- **Update on miss:**
  - BranchE=1: allocate. valid<=1, tag<=PCE tag, target<=BranchTargetE, ctr<=10. This overwrites any aliasing entry.
  - BranchE=0: no write.
- **Misprediction (combinational, gated by updE):**
  - MispredictE = (BranchE != PredictedTakenE) || (BranchE && PredictedTakenE && PredictedTargetE != BranchTargetE).
  - RecoveryPCE = BranchE ? BranchTargetE : PCE + 4. Arithmetic is 32-bit modulo, so PCE=FFFFFFFC gives 00000000.
  - MispredictE=0 whenever updE=0.

## Timing
- Lookup outputs are combinational from PCF and current table state, with zero latency.
- MispredictE and RecoveryPCE are combinational from the EX inputs in the same cycle.
- Table writes occur at the rising edge of the cycle in which updE=1 and become visible to lookups the next cycle.
- Read-during-write: when PCF and PCE map to the same index in the same cycle, the lookup returns the pre-write contents.
- Reset (synchronous, in any cycle including mid-training):
  - All valid<=0, ctr<=01, target<=0, tag<=0; statistics counters <=0.
  - While rst=1: PredictTakenF=0, PredictedTargetF=0, MispredictE=0, RecoveryPCE=PCE+4, and no update occurs.
  - The first cycle after rst falls, every lookup misses.
- Back-to-back updates to the same entry on consecutive cycles each apply their increment or decrement.

## Configuration
- Macro: `BTB_STATS_EN`.
- **Defined:**
  - BranchCountS increments on every cycle with updE=1.
  - MispredictCountS increments on every cycle with MispredictE=1.
  - Both saturate at FFFFFFFF and are cleared by rst.
- **Undefined:** both ports are tied to 0 and no counter flops are synthesized. Prediction behaviour is identical in both builds.

## Test plan
- **Reset:** rst=1 for 2 cycles, then PCF=00000040 → PredictTakenF=0 and PredictedTargetF=0. With `BTB_STATS_EN` defined, both count ports read 0.
- **Allocate:**
  - Stimulus: EX BEQ, PCE=00000040, BranchE=1, BranchTargetE=00000100, PredictedTakenE=0.
  - Same cycle: MispredictE=1, RecoveryPCE=00000100.
  - Next cycle, PCF=00000040: PredictTakenF=1, PredictedTargetF=00000100.
- **Saturation:** train PCE=00000040 taken 3 more times, then not-taken once → still predicts taken (ctr 11→10). A second not-taken → PredictTakenF=0 (ctr 01).
- **Not-taken recovery:** PCE=FFFFFFFC, BranchE=0, PredictedTakenE=1 → MispredictE=1, RecoveryPCE=00000000. No allocation on the miss.
- **Alias and read-during-write** (INDEX_W=4):
  - Taken branch at PCE=00000080 evicts the entry for 00000040; afterwards PCF=00000040 misses.
  - Same cycle PCF=PCE=00000080 on first allocation → lookup misses that cycle and hits the next.
- **Bubble and statistics:** BranchTypeE=NOBRANCH with BranchE=1 → MispredictE=0, no table change. With `BTB_STATS_EN`, after the scenarios above the count ports equal the exact number of updates and mispredictions.
